// File: rtl/sbox_sub_pipe_pkg.sv
// Shared AES byte-substitution definitions: lane type, mode encoding,
// forward/inverse S-box tables and the table lookup helper.
package sbox_sub_pipe_pkg;

    typedef logic [7:0] byte_t;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    localparam byte_t SBOX_FWD [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam byte_t SBOX_INV [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Single-byte substitution, direction chosen by mode
    function automatic byte_t sbox_sub(input byte_t b, input logic mode);
        byte_t r;
        if (mode == MODE_DEC) begin
            r = SBOX_INV[b];
        end else begin
            r = SBOX_FWD[b];
        end
        return r;
    endfunction

endpackage

// File: rtl/sbox_sub_pipe_lane.sv
// One combinational byte lane: forward or inverse AES S-box lookup.
module sbox_lane
    import sbox_sub_pipe_pkg::*;
(
    input  byte_t din,
    input  logic  mode,
    output byte_t dout
);

    // Table lookup for this lane; every lane shares the beat's mode
    always_comb begin
        dout = 8'h00;
        dout = sbox_sub(din, mode);
    end

endmodule

// File: rtl/sbox_sub_pipe.sv
// Two-stage, flow-controlled multi-lane AES (Inv)SubBytes unit.
// Stage A captures the input beat, the lane lookups sit between A and B,
// stage B holds the registered result presented downstream.
module sbox_sub_pipe
    import sbox_sub_pipe_pkg::*;
#(
    parameter int LANES = 16,
    parameter int TAG_W = 4
)
(
    input  logic               i_Clk,
    input  logic               i_Rst_n,
    input  logic               i_Valid,
    output logic               o_Ready,
    input  logic               i_Mode,
    input  logic [TAG_W-1:0]   i_Tag,
    input  logic [8*LANES-1:0] i_Din,
    output logic               o_Valid,
    input  logic               i_Ready,
    output logic [8*LANES-1:0] o_Dout,
    output logic [TAG_W-1:0]   o_Tag,
    output logic               o_Mode,
    output logic               o_Busy
);

    localparam int DW = 8 * LANES;

    logic             va_r;
    logic             vb_r;
    logic [DW-1:0]    a_din_r;
    logic             a_mode_r;
    logic [TAG_W-1:0] a_tag_r;
    logic [DW-1:0]    b_dout_r;
    logic             b_mode_r;
    logic [TAG_W-1:0] b_tag_r;

    logic [DW-1:0]    sub_s;
    logic             ready_s;
    logic             a_load_s;
    logic             b_load_s;
    logic             out_xfer_s;

    genvar k;
    generate
        for (k = 0; k < LANES; k++) begin : g_lane
            sbox_lane u_lane (
                .din  (a_din_r[8*k +: 8]),
                .mode (a_mode_r),
                .dout (sub_s[8*k +: 8])
            );
        end
    endgenerate

    // Handshake decode; ready is forced low while reset is asserted
    always_comb begin
        ready_s    = 1'b0;
        b_load_s   = 1'b0;
        a_load_s   = 1'b0;
        out_xfer_s = 1'b0;
        out_xfer_s = vb_r & i_Ready;
        b_load_s   = va_r & (~vb_r | i_Ready);
        ready_s    = i_Rst_n & (~va_r | ~vb_r | i_Ready);
        a_load_s   = i_Valid & ready_s;
    end

    // Stage valid bits: loading wins over draining so bubbles collapse
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            va_r <= 1'b0;
            vb_r <= 1'b0;
        end else begin
            if (a_load_s) begin
                va_r <= 1'b1;
            end else if (b_load_s) begin
                va_r <= 1'b0;
            end else begin
                va_r <= va_r;
            end
            if (b_load_s) begin
                vb_r <= 1'b1;
            end else if (out_xfer_s) begin
                vb_r <= 1'b0;
            end else begin
                vb_r <= vb_r;
            end
        end
    end

    // Stage A payload, captured on input transfer only
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            a_din_r  <= '0;
            a_mode_r <= MODE_ENC;
            a_tag_r  <= '0;
        end else if (a_load_s) begin
            a_din_r  <= i_Din;
            a_mode_r <= i_Mode;
            a_tag_r  <= i_Tag;
        end else begin
            a_din_r  <= a_din_r;
            a_mode_r <= a_mode_r;
            a_tag_r  <= a_tag_r;
        end
    end

    // Stage B payload; holds steady while downstream stalls
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            b_dout_r <= '0;
            b_mode_r <= MODE_ENC;
            b_tag_r  <= '0;
        end else if (b_load_s) begin
            b_dout_r <= sub_s;
            b_mode_r <= a_mode_r;
            b_tag_r  <= a_tag_r;
        end else begin
            b_dout_r <= b_dout_r;
            b_mode_r <= b_mode_r;
            b_tag_r  <= b_tag_r;
        end
    end

    assign o_Ready = ready_s;
    assign o_Valid = vb_r;
    assign o_Dout  = b_dout_r;
    assign o_Tag   = b_tag_r;
    assign o_Mode  = b_mode_r;
    assign o_Busy  = va_r | vb_r;

endmodule

// File: tb/tb_sbox_sub_pipe.sv
// Scoreboard bench for sbox_sub_pipe. Expected results come from
// hand-computed vectors and from an S-box model built from GF(2^8) math.
module tb_sbox_sub_pipe;

    localparam int LANES = 16;
    localparam int TAG_W = 8;
    localparam int DW    = 8 * LANES;

    logic             i_Clk = 1'b0;
    logic             i_Rst_n;
    logic             i_Valid;
    logic             o_Ready;
    logic             i_Mode;
    logic [TAG_W-1:0] i_Tag;
    logic [DW-1:0]    i_Din;
    logic             o_Valid;
    logic             i_Ready = 1'b1;
    logic [DW-1:0]    o_Dout;
    logic [TAG_W-1:0] o_Tag;
    logic             o_Mode;
    logic             o_Busy;

    typedef struct {
        logic [DW-1:0]    data;
        logic [TAG_W-1:0] tag;
        logic             mode;
        int               cyc;
        bit               lat;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    int         checks  = 0;
    int         errors  = 0;
    int         cyc     = 0;
    int         out_cnt = 0;
    bit         lat_en  = 1'b0;
    bit         rand_rdy = 1'b0;
    logic       rdy_force = 1'b1;
    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];

    sbox_sub_pipe #(.LANES(LANES), .TAG_W(TAG_W)) dut (
        .i_Clk   (i_Clk),
        .i_Rst_n (i_Rst_n),
        .i_Valid (i_Valid),
        .o_Ready (o_Ready),
        .i_Mode  (i_Mode),
        .i_Tag   (i_Tag),
        .i_Din   (i_Din),
        .o_Valid (o_Valid),
        .i_Ready (i_Ready),
        .o_Dout  (o_Dout),
        .o_Tag   (o_Tag),
        .o_Mode  (o_Mode),
        .o_Busy  (o_Busy)
    );

    always #5 i_Clk = ~i_Clk;

    initial forever begin
        @(posedge i_Clk);
        cyc++;
    end

    // Downstream ready: forced level or 50% random, changed just after the edge
    initial forever begin
        @(posedge i_Clk);
        #2;
        if (rand_rdy) i_Ready = 1'($urandom_range(0, 1));
        else          i_Ready = rdy_force;
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_model(input logic [7:0] a);
        logic [7:0] v;
        v = 8'h01;
        for (int i = 0; i < 254; i++) v = gmul(v, a);
        if (a == 8'h00) v = 8'h00;
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [DW-1:0] model(input logic [DW-1:0] d, input logic m);
        logic [DW-1:0] r;
        r = '0;
        for (int k = 0; k < LANES; k++)
            r[8*k +: 8] = m ? inv_tab[d[8*k +: 8]] : fwd_tab[d[8*k +: 8]];
        return r;
    endfunction

    task automatic cmp(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [DW-1:0] e, input logic m, input logic [TAG_W-1:0] t);
        exp_t x;
        x.data = e; x.tag = t; x.mode = m; x.cyc = cyc; x.lat = lat_en;
        sb_q.push_back(x);
    endtask

    task automatic send(input logic [DW-1:0] d, input logic m, input logic [TAG_W-1:0] t,
                        input logic [DW-1:0] e);
        int n;
        @(posedge i_Clk);
        #1;
        i_Valid = 1'b1; i_Din = d; i_Mode = m; i_Tag = t;
        @(negedge i_Clk);
        n = 0;
        while (!o_Ready && n < 200) begin
            @(negedge i_Clk);
            n++;
        end
        if (o_Ready) begin
            push_exp(e, m, t);
        end else begin
            checks++; errors++;
            $display("FAIL accept_timeout: tag %0h not accepted, expected acceptance within 200 cycles", t);
        end
    endtask

    task automatic idle();
        @(posedge i_Clk);
        #1;
        i_Valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        @(negedge i_Clk);
        while (o_Busy && n < 200) begin
            @(negedge i_Clk);
            n++;
        end
        cmp({name, "_busy"}, DW'(o_Busy), DW'(0));
        cmp({name, "_queue"}, DW'(sb_q.size()), DW'(0));
    endtask

    // Output monitor: pop and compare on each output transfer
    initial forever begin
        @(negedge i_Clk);
        if (!i_Rst_n) begin
            sb_q.delete();
        end else if (o_Valid && i_Ready) begin
            if (sb_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_beat: got tag %0h data %h, expected no output", o_Tag, o_Dout);
            end else begin
                mon_e = sb_q.pop_front();
                out_cnt++;
                cmp("data", o_Dout, mon_e.data);
                cmp("tag", DW'(o_Tag), DW'(mon_e.tag));
                cmp("mode", DW'(o_Mode), DW'(mon_e.mode));
                if (mon_e.lat) cmp("latency", DW'(cyc - mon_e.cyc), DW'(2));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d;
        logic [DW-1:0] prev_d;
        logic [DW-1:0] hold_d;
        logic [TAG_W-1:0] hold_t;
        logic hold_m;
        logic m;
        int base;
        int acc;
        int iter;

        i_Rst_n = 1'b0; i_Valid = 1'b0; i_Mode = 1'b0; i_Tag = '0; i_Din = '0;
        for (int i = 0; i < 256; i++) fwd_tab[i] = sbox_model(8'(i));
        for (int i = 0; i < 256; i++) inv_tab[fwd_tab[i]] = 8'(i);

        repeat (3) @(posedge i_Clk);
        @(negedge i_Clk);
        cmp("rst_valid", DW'(o_Valid), DW'(0));
        cmp("rst_busy", DW'(o_Busy), DW'(0));
        cmp("rst_dout", o_Dout, DW'(0));
        cmp("rst_tag", DW'(o_Tag), DW'(0));
        cmp("rst_mode", DW'(o_Mode), DW'(0));
        cmp("rst_ready_low", DW'(o_Ready), DW'(0));
        @(posedge i_Clk); #1; i_Rst_n = 1'b1;
        @(negedge i_Clk);
        cmp("ready_after_reset", DW'(o_Ready), DW'(1));

        // Directed vectors
        lat_en = 1'b1;
        send({16{8'h00}}, 1'b0, 8'h01, {16{8'h63}});
        send({16{8'h63}}, 1'b1, 8'h02, {16{8'h00}});
        send({{13{8'h00}}, 8'hFF, 8'h53, 8'h01}, 1'b0, 8'h03, {{13{8'h63}}, 8'h16, 8'hED, 8'h7C});
        send({{13{8'h63}}, 8'h16, 8'hED, 8'h7C}, 1'b1, 8'h04, {{13{8'h00}}, 8'hFF, 8'h53, 8'h01});
        send({16{8'hFF}}, 1'b1, 8'h05, {16{8'h7D}});
        idle();
        drain("directed");

        // 32-beat stream, alternating mode, odd beats undo the previous beat
        base = out_cnt;
        prev_d = '0;
        for (int i = 0; i < 32; i++) begin
            if (i % 2 == 0) begin
                prev_d = {$urandom, $urandom, $urandom, $urandom};
                send(prev_d, 1'b0, TAG_W'(i), model(prev_d, 1'b0));
            end else begin
                send(model(prev_d, 1'b0), 1'b1, TAG_W'(i), prev_d);
            end
        end
        idle();
        drain("stream");
        cmp("stream_count", DW'(out_cnt - base), DW'(32));

        // Backpressure: two beats fill the pipe, outputs hold while stalled
        lat_en = 1'b0;
        rdy_force = 1'b0;
        repeat (2) @(posedge i_Clk);
        base = out_cnt;
        @(posedge i_Clk); #1;
        d = {$urandom, $urandom, $urandom, $urandom};
        i_Valid = 1'b1; i_Din = d; i_Mode = 1'b0; i_Tag = 8'h40;
        @(negedge i_Clk);
        cmp("bp_ready0", DW'(o_Ready), DW'(1));
        push_exp(model(d, 1'b0), 1'b0, 8'h40);
        @(posedge i_Clk); #1;
        d = {$urandom, $urandom, $urandom, $urandom};
        i_Din = d; i_Mode = 1'b1; i_Tag = 8'h41;
        @(negedge i_Clk);
        cmp("bp_ready1", DW'(o_Ready), DW'(1));
        push_exp(model(d, 1'b1), 1'b1, 8'h41);
        @(posedge i_Clk); #1;
        d = {$urandom, $urandom, $urandom, $urandom};
        i_Din = d; i_Mode = 1'b0; i_Tag = 8'h42;
        @(negedge i_Clk);
        cmp("bp_full_ready", DW'(o_Ready), DW'(0));
        cmp("bp_full_valid", DW'(o_Valid), DW'(1));
        hold_d = o_Dout; hold_t = o_Tag; hold_m = o_Mode;
        for (int i = 0; i < 5; i++) begin
            @(negedge i_Clk);
            cmp("bp_hold_dout", o_Dout, hold_d);
            cmp("bp_hold_tag", DW'(o_Tag), DW'(hold_t));
            cmp("bp_hold_mode", DW'(o_Mode), DW'(hold_m));
            cmp("bp_hold_ready", DW'(o_Ready), DW'(0));
        end
        rdy_force = 1'b1;
        send(d, 1'b0, 8'h42, model(d, 1'b0));
        d = {$urandom, $urandom, $urandom, $urandom};
        send(d, 1'b1, 8'h43, model(d, 1'b1));
        idle();
        drain("backpressure");
        cmp("bp_count", DW'(out_cnt - base), DW'(4));

        // Random valid/ready for 1000 accepted beats
        base = out_cnt;
        rand_rdy = 1'b1;
        acc = 0;
        iter = 0;
        while (acc < 1000 && iter < 20000) begin
            @(posedge i_Clk); #1;
            i_Valid = 1'($urandom_range(0, 1));
            if (i_Valid) begin
                m = 1'($urandom_range(0, 1));
                d = {$urandom, $urandom, $urandom, $urandom};
                i_Din = d; i_Mode = m; i_Tag = TAG_W'(acc);
            end
            @(negedge i_Clk);
            if (i_Valid && o_Ready) begin
                push_exp(model(i_Din, i_Mode), i_Mode, i_Tag);
                acc++;
            end
            iter++;
        end
        cmp("random_accepted", DW'(acc), DW'(1000));
        idle();
        rand_rdy = 1'b0;
        rdy_force = 1'b1;
        drain("random");
        cmp("random_count", DW'(out_cnt - base), DW'(1000));

        // Reset with both stages full and downstream stalled
        rdy_force = 1'b0;
        repeat (2) @(posedge i_Clk);
        d = {$urandom, $urandom, $urandom, $urandom};
        send(d, 1'b0, 8'hA0, model(d, 1'b0));
        send(d, 1'b1, 8'hA1, model(d, 1'b1));
        @(posedge i_Clk); #1;
        i_Valid = 1'b0;
        i_Rst_n = 1'b0;
        @(negedge i_Clk);
        cmp("full_before_reset", DW'(o_Busy), DW'(1));
        cmp("ready_in_reset", DW'(o_Ready), DW'(0));
        @(negedge i_Clk);
        cmp("midrst_valid", DW'(o_Valid), DW'(0));
        cmp("midrst_busy", DW'(o_Busy), DW'(0));
        cmp("midrst_dout", o_Dout, DW'(0));
        @(posedge i_Clk); #1;
        i_Rst_n = 1'b1;
        rdy_force = 1'b1;
        @(negedge i_Clk);
        cmp("ready_after_midrst", DW'(o_Ready), DW'(1));
        base = out_cnt;
        lat_en = 1'b1;
        send({16{8'h01}}, 1'b0, 8'hB0, {16{8'h7C}});
        idle();
        drain("post_reset");
        repeat (3) @(negedge i_Clk);
        cmp("post_reset_count", DW'(out_cnt - base), DW'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
